// File: rtl/conv_engine.sv
// rtl/conv_engine.sv - 3x3 signed-kernel convolution over a byte image in external memory
module conv_engine #(
    parameter int ImgWidth  = 16,
    parameter int ImgHeight = 10,
    parameter int OutBase   = 160
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [35:0] Kernel,
    output logic [15:0] MemAddress,
    input  logic [7:0]  MemDataIn,
    output logic [7:0]  MemDataOut,
    output logic        WriteFlag,
    output logic        Busy,
    output logic        DoneFlag
);
    localparam int ColW = $clog2(ImgWidth);
    localparam int RowW = $clog2(ImgHeight);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [35:0]        r_kernel;
    logic [ColW-1:0]    r_col;
    logic [RowW-1:0]    r_row;
    logic [3:0]         r_tap;
    logic [1:0]         r_kx;
    logic [1:0]         r_ky;
    logic signed [15:0] r_acc;

    logic               w_accept;
    logic               w_last_tap;
    logic               w_last_col;
    logic               w_last_pix;
    logic signed [3:0]  w_coef;
    logic signed [12:0] w_pix13;
    logic signed [12:0] w_coef13;
    logic signed [12:0] w_prod;
    logic [15:0]        w_rd_addr;
    logic [15:0]        w_wr_addr;
    logic [7:0]         w_clamped;

    assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && Start;
    assign w_last_tap = (r_tap == 4'd8);
    assign w_last_col = (r_col == ColW'(ImgWidth - 3));
    assign w_last_pix = w_last_col && (r_row == RowW'(ImgHeight - 3));

    // Pixel is unsigned, coefficient signed: worst case 255*-8 fits 13 bits signed
    assign w_coef   = r_kernel[{r_tap, 2'b00} +: 4];
    assign w_pix13  = {5'b0, MemDataIn};
    assign w_coef13 = {{9{w_coef[3]}}, w_coef};
    assign w_prod   = w_pix13 * w_coef13;

    assign w_rd_addr = (16'(r_row) + 16'(r_ky)) * 16'(ImgWidth) + 16'(r_col) + 16'(r_kx);
    assign w_wr_addr = 16'(OutBase) + 16'(r_row) * 16'(ImgWidth - 2) + 16'(r_col);

    always_comb begin
        if (r_acc[15]) begin
            w_clamped = 8'd0;
        end else if (r_acc > 16'sd255) begin
            w_clamped = 8'hFF;
        end else begin
            w_clamped = r_acc[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        Busy       = 1'b0;
        WriteFlag  = 1'b0;
        DoneFlag   = 1'b0;
        MemAddress = 16'd0;
        MemDataOut = 8'd0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next = READ;
                end
            end
            READ: begin
                Busy       = 1'b1;
                MemAddress = w_rd_addr;
                if (w_last_tap) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                Busy       = 1'b1;
                WriteFlag  = 1'b1;
                MemAddress = w_wr_addr;
                MemDataOut = w_clamped;
                w_next     = w_last_pix ? DONE : READ;
            end
            DONE: begin
                DoneFlag = 1'b1;
                if (Start) begin
                    w_next = READ;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_kernel <= 36'd0;
            r_col    <= '0;
            r_row    <= '0;
            r_tap    <= 4'd0;
            r_kx     <= 2'd0;
            r_ky     <= 2'd0;
            r_acc    <= 16'sd0;
        end else if (w_accept) begin
            r_kernel <= Kernel;
            r_col    <= '0;
            r_row    <= '0;
            r_tap    <= 4'd0;
            r_kx     <= 2'd0;
            r_ky     <= 2'd0;
            r_acc    <= 16'sd0;
        end else if (r_state == READ) begin
            r_acc <= r_acc + {{3{w_prod[12]}}, w_prod};
            if (w_last_tap) begin
                r_tap <= 4'd0;
                r_kx  <= 2'd0;
                r_ky  <= 2'd0;
            end else begin
                r_tap <= r_tap + 4'd1;
                if (r_kx == 2'd2) begin
                    r_kx <= 2'd0;
                    r_ky <= r_ky + 2'd1;
                end else begin
                    r_kx <= r_kx + 2'd1;
                end
            end
        end else if (r_state == WRITE) begin
            r_acc <= 16'sd0;
            if (w_last_pix) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + RowW'(1);
            end else begin
                r_col <= r_col + ColW'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// tb/tb_conv_engine.sv - scoreboard bench for conv_engine with directed kernels and images
module tb_conv_engine;
    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [35:0] Kernel;
    logic [15:0] MemAddress;
    logic [7:0]  MemDataIn;
    logic [7:0]  MemDataOut;
    logic        WriteFlag;
    logic        Busy;
    logic        DoneFlag;

    logic [7:0]  mem [0:511];
    logic [23:0] exp_q [$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          n_writes = 0;
    int          cyc;

    localparam logic [35:0] KIdent = 36'h000010000;
    localparam logic [35:0] KMix   = 36'h00002000F;
    localparam logic [35:0] KOnes  = 36'h111111111;
    localparam logic [35:0] KSev   = 36'h777777777;
    localparam logic [35:0] KNeg8  = 36'h888888888;

    always #5 clk = ~clk;

    assign MemDataIn = mem[MemAddress[8:0]];

    conv_engine #(.ImgWidth(16), .ImgHeight(10), .OutBase(160)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Kernel     (Kernel),
        .MemAddress (MemAddress),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .WriteFlag  (WriteFlag),
        .Busy       (Busy),
        .DoneFlag   (DoneFlag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ramp byte j = j mod 256; otherwise every byte equals mode
    task automatic fill_image(input int mode);
        for (int j = 0; j < 160; j++) begin
            mem[j] = (mode == 0) ? 8'(j) : 8'(mode);
        end
    endtask

    // kind 0: identity on ramp; kind 1: 2*center - topleft on ramp; else constant cval
    task automatic expect_pass(input int kind, input logic [7:0] cval);
        int d;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 14; c++) begin
                if (kind == 0)      d = (r + 1) * 16 + c + 1;
                else if (kind == 1) d = 16 * r + c + 34;
                else                d = cval;
                exp_q.push_back({16'(160 + r * 14 + c), 8'(d)});
            end
        end
    endtask

    task automatic run_pass(input logic [35:0] k, input bit extra_starts);
        int w0;
        w0     = n_writes;
        Kernel = k;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
        for (cyc = 1; cyc <= 1121; cyc++) begin
            if (cyc == 1) begin
                chk("busy_after_accept", Busy, 1);
                chk("done_after_accept", DoneFlag, 0);
            end
            if (cyc == 9)    chk("no_write_cycle9", WriteFlag, 0);
            if (cyc == 10)   chk("first_write_cycle10", WriteFlag, 1);
            if (cyc == 1120) chk("done_low_cycle1120", DoneFlag, 0);
            if (cyc == 1121) begin
                chk("done_cycle1121", DoneFlag, 1);
                chk("busy_cycle1121", Busy, 0);
                chk("addr_in_done", MemAddress, 0);
                chk("dout_in_done", MemDataOut, 0);
            end
            Start = extra_starts && (cyc == 5 || cyc == 600);
            if (cyc < 1121) tick();
        end
        repeat (4) tick();
        chk("done_held", DoneFlag, 1);
        chk("writes_per_pass", n_writes - w0, 112);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        if (WriteFlag === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", MemAddress, MemDataOut);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", MemAddress, e[23:8]);
                chk("write_data", MemDataOut, e[7:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        Reset  = 1'b1;
        Start  = 1'b1;
        Kernel = KIdent;
        fill_image(0);
        for (int j = 160; j < 512; j++) mem[j] = 8'd0;
        tick();
        tick();
        chk("rst_busy", Busy, 0);
        chk("rst_done", DoneFlag, 0);
        chk("rst_wflag", WriteFlag, 0);
        chk("rst_addr", MemAddress, 0);
        chk("rst_dout", MemDataOut, 0);
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        chk("idle_busy", Busy, 0);

        expect_pass(0, 8'd0);
        run_pass(KIdent, 1'b1);

        expect_pass(1, 8'd0);
        run_pass(KMix, 1'b0);

        fill_image(200);
        expect_pass(2, 8'd255);
        run_pass(KOnes, 1'b0);

        fill_image(255);
        expect_pass(2, 8'd255);
        run_pass(KSev, 1'b0);

        expect_pass(2, 8'd0);
        run_pass(KNeg8, 1'b0);

        // Start held high: second pass begins on the first edge in DONE
        fill_image(0);
        expect_pass(0, 8'd0);
        expect_pass(0, 8'd0);
        w      = n_writes;
        Kernel = KIdent;
        Start  = 1'b1;
        tick();
        for (cyc = 1; cyc < 1121; cyc++) tick();
        chk("held_done_1121", DoneFlag, 1);
        chk("held_busy_1121", Busy, 0);
        tick();
        chk("held_busy_1122", Busy, 1);
        chk("held_done_1122", DoneFlag, 0);
        Start = 1'b0;
        for (cyc = 1122; cyc < 2242; cyc++) tick();
        chk("held_done_2242", DoneFlag, 1);
        chk("held_writes", n_writes - w, 224);

        // Reset in cycle 500 aborts the pass
        expect_pass(0, 8'd0);
        Kernel = KIdent;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
        for (cyc = 1; cyc < 500; cyc++) tick();
        Reset = 1'b1;
        tick();
        chk("abort_busy", Busy, 0);
        chk("abort_done", DoneFlag, 0);
        chk("abort_wflag", WriteFlag, 0);
        chk("abort_addr", MemAddress, 0);
        chk("abort_dout", MemDataOut, 0);
        Reset = 1'b0;
        exp_q.delete();
        w = n_writes;
        repeat (30) tick();
        chk("abort_no_writes", n_writes - w, 0);
        chk("abort_idle_busy", Busy, 0);

        expect_pass(0, 8'd0);
        run_pass(KIdent, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
